lsu_mem_arbiter: RTL and testbench

- Shares a small number of data-memory channels between the per-thread LSU requesters of a core.
- Each requester issues one read or one write at a time using a four-phase valid/ready handshake.
- The arbiter grants requesters to free channels in round-robin order, forwards each request to memory, and relays the response back.
- It sits between the core's per-thread data-memory ports and the global data memory.

---
 rtl/lsu_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 32 +++
 rtl/lsu_mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and helpers for the LSU data-memory arbiter.
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELAY
    } channel_state_t;

    // Round-robin pointer width; never zero so single-requester builds still elaborate.
    function automatic int unsigned ptr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping to 0.
module rr_pick
    import lsu_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = ptr_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    // Pass one scans ptr..N-1, pass two wraps and scans from 0.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < int'(N); j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
        for (int j = 0; j < int'(N); j++) begin
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS data-memory channels between per-thread LSUs.
module lsu_mem_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int unsigned PW = ptr_bits(NUM_CONSUMERS);

    channel_state_t                          state_q [NUM_CHANNELS];
    channel_state_t                          state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][PW-1:0]         owner_q, owner_d;
    logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
    logic [PW-1:0]                           ptr_q, ptr_d;
    logic [NUM_CONSUMERS-1:0]                c_rr_q, c_rr_d, c_wr_q, c_wr_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] c_rd_q, c_rd_d;
    logic [NUM_CHANNELS-1:0]                 m_rv_q, m_rv_d, m_wv_q, m_wv_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  m_ra_q, m_ra_d, m_wa_q, m_wa_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  m_wd_q, m_wd_d;

    logic [NUM_CONSUMERS-1:0]        pending;
    logic [NUM_CHANNELS-1:0]         grant;
    logic [NUM_CHANNELS-1:0][PW-1:0] grant_idx;
    logic [PW-1:0]                   ptr_next;

    assign pending = (consumer_read_valid | consumer_write_valid) & ~claim_q;

    // Channels pick in ascending order; each stage removes its pick and advances the pointer.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] avail_in;
        logic [PW-1:0]            ptr_in, ptr_out, idx;
        logic                     found, gnt;

        if (c == 0) begin : g_head
            assign avail_in = pending;
            assign ptr_in   = ptr_q;
        end else begin : g_link
            assign avail_in = g_ch[c-1].g_fwd.avail_out;
            assign ptr_in   = g_ch[c-1].ptr_out;
        end

        rr_pick #(
            .N  (NUM_CONSUMERS),
            .PW (PW)
        ) u_pick (
            .req   (avail_in),
            .ptr   (ptr_in),
            .found (found),
            .idx   (idx)
        );

        assign gnt     = found && (state_q[c] == IDLE);
        assign ptr_out = !gnt ? ptr_in :
                         (idx == PW'(NUM_CONSUMERS - 1)) ? '0 : idx + PW'(1);

        if (c < NUM_CHANNELS - 1) begin : g_fwd
            logic [NUM_CONSUMERS-1:0] avail_out;
            assign avail_out = gnt ? (avail_in & ~(NUM_CONSUMERS'(1) << idx)) : avail_in;
        end

        assign grant[c]     = gnt;
        assign grant_idx[c] = idx;
    end

    assign ptr_next = g_ch[NUM_CHANNELS-1].ptr_out;

    // Per-channel next state plus the shared claim mask and relayed handshake registers.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        claim_d = claim_q;
        ptr_d   = ptr_next;
        c_rr_d  = c_rr_q;
        c_wr_d  = c_wr_q;
        c_rd_d  = c_rd_q;
        m_rv_d  = m_rv_q;
        m_wv_d  = m_wv_q;
        m_ra_d  = m_ra_q;
        m_wa_d  = m_wa_q;
        m_wd_d  = m_wd_q;
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            unique case (state_q[c])
                IDLE: begin
                    if (grant[c]) begin
                        owner_d[c]              = grant_idx[c];
                        claim_d[grant_idx[c]]   = 1'b1;
                        // Read wins when both are raised; the write is picked up later.
                        if (consumer_read_valid[grant_idx[c]]) begin
                            state_d[c] = READ_WAIT;
                            m_rv_d[c]  = 1'b1;
                            m_ra_d[c]  = consumer_read_address[grant_idx[c]];
                        end else begin
                            state_d[c] = WRITE_WAIT;
                            m_wv_d[c]  = 1'b1;
                            m_wa_d[c]  = consumer_write_address[grant_idx[c]];
                            m_wd_d[c]  = consumer_write_data[grant_idx[c]];
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        m_rv_d[c]            = 1'b0;
                        c_rd_d[owner_q[c]]   = mem_read_data[c];
                        c_rr_d[owner_q[c]]   = 1'b1;
                        state_d[c]           = RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        m_wv_d[c]            = 1'b0;
                        c_wr_d[owner_q[c]]   = 1'b1;
                        state_d[c]           = RELAY;
                    end
                end
                RELAY: begin
                    // The raised ready tells which request kind this channel is relaying.
                    if (c_rr_q[owner_q[c]]) begin
                        if (!consumer_read_valid[owner_q[c]]) begin
                            c_rr_d[owner_q[c]]  = 1'b0;
                            claim_d[owner_q[c]] = 1'b0;
                            state_d[c]          = IDLE;
                        end
                    end else if (!consumer_write_valid[owner_q[c]]) begin
                        c_wr_d[owner_q[c]]  = 1'b0;
                        claim_d[owner_q[c]] = 1'b0;
                        state_d[c]          = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                state_q[c] <= IDLE;
            end
            owner_q <= '0;
            claim_q <= '0;
            ptr_q   <= '0;
            c_rr_q  <= '0;
            c_wr_q  <= '0;
            c_rd_q  <= '0;
            m_rv_q  <= '0;
            m_wv_q  <= '0;
            m_ra_q  <= '0;
            m_wa_q  <= '0;
            m_wd_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            claim_q <= claim_d;
            ptr_q   <= ptr_d;
            c_rr_q  <= c_rr_d;
            c_wr_q  <= c_wr_d;
            c_rd_q  <= c_rd_d;
            m_rv_q  <= m_rv_d;
            m_wv_q  <= m_wv_d;
            m_ra_q  <= m_ra_d;
            m_wa_q  <= m_wa_d;
            m_wd_q  <= m_wd_d;
        end
    end

    assign consumer_read_ready  = c_rr_q;
    assign consumer_read_data   = c_rd_q;
    assign consumer_write_ready = c_wr_q;
    assign mem_read_valid       = m_rv_q;
    assign mem_read_address     = m_ra_q;
    assign mem_write_valid      = m_wv_q;
    assign mem_write_address    = m_wa_q;
    assign mem_write_data       = m_wd_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: a 1-channel and a 2-channel instance, each with a small memory model.
module tb_lsu_mem_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned AB = 8;
    localparam int unsigned DB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int unsigned mem_delay;

    // Instance A: one channel.
    logic [NC-1:0]         a_rv, a_wv, a_rr, a_wr;
    logic [NC-1:0][AB-1:0] a_ra, a_wa;
    logic [NC-1:0][DB-1:0] a_rd, a_wd;
    logic [0:0]            a_mrv, a_mrr, a_mwv, a_mwr;
    logic [0:0][AB-1:0]    a_mra, a_mwa;
    logic [0:0][DB-1:0]    a_mrd, a_mwd;

    // Instance B: two channels.
    logic [NC-1:0]         b_rv, b_wv, b_rr, b_wr;
    logic [NC-1:0][AB-1:0] b_ra, b_wa;
    logic [NC-1:0][DB-1:0] b_rd, b_wd;
    logic [1:0]            b_mrv, b_mrr, b_mwv, b_mwr;
    logic [1:0][AB-1:0]    b_mra, b_mwa;
    logic [1:0][DB-1:0]    b_mrd, b_mwd;

    lsu_mem_arbiter #(
        .ADDR_BITS (AB), .DATA_BITS (DB), .NUM_CONSUMERS (NC), .NUM_CHANNELS (1)
    ) dut_a (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (a_rv),
        .consumer_read_address  (a_ra),
        .consumer_read_ready    (a_rr),
        .consumer_read_data     (a_rd),
        .consumer_write_valid   (a_wv),
        .consumer_write_address (a_wa),
        .consumer_write_data    (a_wd),
        .consumer_write_ready   (a_wr),
        .mem_read_valid         (a_mrv),
        .mem_read_address       (a_mra),
        .mem_read_ready         (a_mrr),
        .mem_read_data          (a_mrd),
        .mem_write_valid        (a_mwv),
        .mem_write_address      (a_mwa),
        .mem_write_data         (a_mwd),
        .mem_write_ready        (a_mwr)
    );

    lsu_mem_arbiter #(
        .ADDR_BITS (AB), .DATA_BITS (DB), .NUM_CONSUMERS (NC), .NUM_CHANNELS (2)
    ) dut_b (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (b_rv),
        .consumer_read_address  (b_ra),
        .consumer_read_ready    (b_rr),
        .consumer_read_data     (b_rd),
        .consumer_write_valid   (b_wv),
        .consumer_write_address (b_wa),
        .consumer_write_data    (b_wd),
        .consumer_write_ready   (b_wr),
        .mem_read_valid         (b_mrv),
        .mem_read_address       (b_mra),
        .mem_read_ready         (b_mrr),
        .mem_read_data          (b_mrd),
        .mem_write_valid        (b_mwv),
        .mem_write_address      (b_mwa),
        .mem_write_data         (b_mwd),
        .mem_write_ready        (b_mwr)
    );

    // Memory A: mem[k] = 2k+1 after reset; ready once valid has been seen mem_delay edges.
    logic [DB-1:0] mem_a [256];
    int unsigned   a_cnt;
    assign a_mrr[0] = a_mrv[0] && (a_cnt >= mem_delay);
    assign a_mwr[0] = a_mwv[0] && (a_cnt >= mem_delay);
    assign a_mrd[0] = mem_a[a_mra[0]];

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) mem_a[k] <= DB'(2 * k + 1);
            a_cnt <= 0;
        end else begin
            a_cnt <= (a_mrv[0] || a_mwv[0]) ? a_cnt + 1 : 0;
            if (a_mwv[0] && a_mwr[0]) mem_a[a_mwa[0]] <= a_mwd[0];
        end
    end

    // Memory B: zero-delay, records which channel wrote each address and how often.
    logic [DB-1:0] mem_b [256];
    int            wr_chan [256];
    int unsigned   wr_count [256];
    assign b_mrr    = b_mrv;
    assign b_mwr    = b_mwv;
    assign b_mrd[0] = mem_b[b_mra[0]];
    assign b_mrd[1] = mem_b[b_mra[1]];

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) begin
                mem_b[k]    <= 8'hFF;
                wr_chan[k]  <= -1;
                wr_count[k] <= 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (b_mwv[c] && b_mwr[c]) begin
                    mem_b[b_mwa[c]]    <= b_mwd[c];
                    wr_chan[b_mwa[c]]  <= c;
                    wr_count[b_mwa[c]] <= wr_count[b_mwa[c]] + 1;
                end
            end
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic [3:0] wv;
        logic [3:0] rr;
        logic [3:0] wr;
        logic       mrv;
        logic       mwv;
        logic [7:0] maddr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [3:0] rv, input logic [3:0] wv,
                       input logic [3:0] rr, input logic [3:0] wr, input logic mrv,
                       input logic mwv, input logic [7:0] maddr);
        vec_t v;
        v.rst = rst; v.rv = rv; v.wv = wv; v.rr = rr; v.wr = wr;
        v.mrv = mrv; v.mwv = mwv; v.maddr = maddr;
        vq.push_back(v);
    endtask

    initial begin
        logic [3:0] prev_wr;
        int         rise_cnt [4];
        int         rise_cyc [4];
        int         n_valid;
        int         lat;
        logic       got;

        reset = 1'b1;
        mem_delay = 0;
        a_rv = '0; a_wv = '0; b_rv = '0; b_wv = '0;
        for (int i = 0; i < 4; i++) begin
            a_ra[i] = AB'(i + 1);
            a_wa[i] = AB'(8'h10 + i);
            a_wd[i] = DB'(8'hA0 + i);
            b_ra[i] = '0;
            b_wa[i] = AB'(i);
            b_wd[i] = DB'(i);
        end

        //   rst rv    wv    rr    wr    mrv   mwv   maddr
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);  // reset state
        add(0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h03);  // single read, req 2
        add(0, 4'h4, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h4, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);  // ptr back to 0
        add(0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h01);  // 4 reads: order 0,1,2,3
        add(0, 4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'hE, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'hE, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h02);
        add(0, 4'hE, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'hC, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'hC, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h03);
        add(0, 4'hC, 4'h0, 4'h4, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h04);
        add(0, 4'h8, 4'h0, 4'h8, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'hA, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h02);  // wrapped ptr=0: order 1,3
        add(0, 4'hA, 4'h0, 4'h2, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h04);
        add(0, 4'h8, 4'h0, 4'h8, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 8'h01);  // read+write on req 0: read first
        add(0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
        add(0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 8'h10);
        add(0, 4'h0, 4'h1, 4'h0, 4'h1, 1'b0, 1'b0, 8'h00);
        add(0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);

        foreach (vq[k]) begin
            reset = vq[k].rst;
            a_rv  = vq[k].rv;
            a_wv  = vq[k].wv;
            @(posedge clk);
            #1;
            check($sformatf("v%0d rd_ready", k), 32'(a_rr), 32'(vq[k].rr));
            check($sformatf("v%0d wr_ready", k), 32'(a_wr), 32'(vq[k].wr));
            check($sformatf("v%0d mem_rv", k), 32'(a_mrv), 32'(vq[k].mrv));
            check($sformatf("v%0d mem_wv", k), 32'(a_mwv), 32'(vq[k].mwv));
            if (vq[k].mrv) check($sformatf("v%0d mem_ra", k), 32'(a_mra[0]), 32'(vq[k].maddr));
            if (vq[k].mwv) begin
                check($sformatf("v%0d mem_wa", k), 32'(a_mwa[0]), 32'(vq[k].maddr));
                check($sformatf("v%0d mem_wd", k), 32'(a_mwd[0]), 32'(8'hA0));
            end
            for (int i = 0; i < 4; i++) begin
                if (vq[k].rr[i]) check($sformatf("v%0d rd_data%0d", k, i), 32'(a_rd[i]),
                                       32'(2 * (i + 1) + 1));
            end
        end
        check("write landed", 32'(mem_a[8'h10]), 32'(8'hA0));

        // Memory ready delayed: mem valid and address held, consumer ready only afterwards.
        mem_delay = 5;
        a_rv = 4'h2;
        n_valid = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (a_rr[1]) begin
                got = 1'b1;
            end else if (a_mrv[0]) begin
                n_valid++;
                check("delay addr stable", 32'(a_mra[0]), 32'h2);
            end
        end
        check("delay ready seen", 32'(got), 32'h1);
        check("delay valid cycles", 32'(n_valid), 32'(mem_delay + 1));
        check("delay mem_rv low", 32'(a_mrv), 32'h0);
        check("delay data", 32'(a_rd[1]), 32'h5);
        a_rv = 4'h0;
        @(posedge clk);
        #1;
        check("delay release", 32'(a_rr), 32'h0);

        // Reset while a read is outstanding.
        a_rv = 4'h1;
        @(posedge clk);
        #1;
        check("pre-reset mem_rv", 32'(a_mrv), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_rv = 4'h0;
        @(posedge clk);
        #1;
        check("rst mem_rv", 32'(a_mrv), 32'h0);
        check("rst mem_wv", 32'(a_mwv), 32'h0);
        check("rst rd_ready", 32'(a_rr), 32'h0);
        check("rst wr_ready", 32'(a_wr), 32'h0);
        check("rst claim", 32'(dut_a.claim_q), 32'h0);
        check("rst ptr", 32'(dut_a.ptr_q), 32'h0);
        reset = 1'b0;
        mem_delay = 0;
        a_rv = 4'h8;
        got = 1'b0;
        lat = -1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk);
            #1;
            if (a_rr[3]) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("post-rst ready", 32'(got), 32'h1);
        check("post-rst latency", 32'(lat), 32'h1);
        check("post-rst data", 32'(a_rd[3]), 32'h9);
        a_rv = 4'h0;
        @(posedge clk);
        #1;
        check("post-rst release", 32'(a_rr), 32'h0);

        // Two channels, four concurrent writes of the thread id.
        b_wv = 4'hF;
        prev_wr = 4'h0;
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] = 0;
            rise_cyc[i] = -1;
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1) begin
                check("2ch first grants", 32'(b_mwv), 32'h3);
                check("2ch ch0 addr", 32'(b_mwa[0]), 32'h0);
                check("2ch ch1 addr", 32'(b_mwa[1]), 32'h1);
            end
            for (int i = 0; i < 4; i++) begin
                if (b_wr[i] && !prev_wr[i]) begin
                    rise_cnt[i]++;
                    rise_cyc[i] = cyc;
                end
                if (b_wr[i]) b_wv[i] = 1'b0;
            end
            prev_wr = b_wr;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("2ch ready rises %0d", i), 32'(rise_cnt[i]), 32'h1);
            check($sformatf("2ch ready cycle %0d", i), 32'(rise_cyc[i]), 32'(i < 2 ? 2 : 5));
            check($sformatf("2ch mem %0d", i), 32'(mem_b[i]), 32'(i));
            check($sformatf("2ch channel %0d", i), 32'(wr_chan[i]), 32'(i % 2));
            check($sformatf("2ch write count %0d", i), 32'(wr_count[i]), 32'h1);
        end
        check("2ch idle", 32'({b_mwv, b_wr}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
